// File: rtl/pea_pkg.sv
// Shared PEA definitions: status token layout, error codes, reader FSM encoding
// and the log2 helper used to size population ports.
package pea_pkg;

    // Status token layout: [15:8] opcode echo, [7:3] result count, [2:0] error code.
    localparam int OPCODE_LSB = 8;
    localparam int OPCODE_W   = 8;
    localparam int COUNT_LSB  = 3;
    localparam int COUNT_W    = 5;
    localparam int ERR_LSB    = 0;
    localparam int ERR_W      = 3;

    localparam logic [ERR_W-1:0] ERR_NONE    = 3'b000;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'b111;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_POP_ST   = 4'd1;
    localparam logic [3:0] ST_LAT_ST   = 4'd2;
    localparam logic [3:0] ST_SEND_ST  = 4'd3;
    localparam logic [3:0] ST_WAIT_RES = 4'd4;
    localparam logic [3:0] ST_POP_RES  = 4'd5;
    localparam logic [3:0] ST_LAT_RES  = 4'd6;
    localparam logic [3:0] ST_SEND_RES = 4'd7;
    localparam logic [3:0] ST_SEND_TO  = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_POP_ST   = ST_POP_ST,
        S_LAT_ST   = ST_LAT_ST,
        S_SEND_ST  = ST_SEND_ST,
        S_WAIT_RES = ST_WAIT_RES,
        S_POP_RES  = ST_POP_RES,
        S_LAT_RES  = ST_LAT_RES,
        S_SEND_RES = ST_SEND_RES,
        S_SEND_TO  = ST_SEND_TO
    } state_t;

    // Ceiling log2; log2(1024) = 10.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pea_fifo_pop.sv
// Single FIFO pop helper: qualified read strobe, capture of the read data one
// cycle later, and a hold register that keeps the token until the next pop.
module pea_fifo_pop #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop,
    input  logic             avail,
    input  logic [WIDTH-1:0] rd_data,
    output logic             rd_en,
    output logic [WIDTH-1:0] data
);

    logic capture;

    // Never strobe an empty FIFO, even if the requester asks for it.
    assign rd_en = pop && avail;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            capture <= 1'b0;
            // NOTE: the hold register is reset because it drives the output bus
            // directly; a plain storage array would not need it.
            data    <= '0;
        end else begin
            capture <= rd_en;
            if (capture) data <= rd_data;
        end
    end

endmodule

// File: rtl/pea_result_reader.sv
// Drains status/result token groups from the PEA output FIFOs onto one
// valid/ready stream. Optional WAIT_RES watchdog: define PEA_READER_TIMEOUT_EN.
module pea_result_reader
    import pea_pkg::*;
#(
    parameter int buffer_size    = 1024,
    parameter int result_size    = 32,
    parameter int status_size    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [log2(buffer_size)-1:0] status_population,
    output logic                         status_rd_en,
    input  logic [status_size-1:0]       status_data,
    input  logic [log2(buffer_size)-1:0] result_population,
    output logic                         result_rd_en,
    input  logic [result_size-1:0]       result_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [result_size-1:0]       out_data,
    output logic                         out_is_status,
    output logic                         out_last,
    output logic                         out_err
);

    localparam int POP_W = log2(buffer_size);

    state_t                 state;
    state_t                 next_state;
    logic                   st_pop;
    logic                   res_pop;
    logic                   load_remaining;
    logic [status_size-1:0] status_hold;
    logic [result_size-1:0] result_hold;
    logic [COUNT_W-1:0]     remaining;
    logic [COUNT_W-1:0]     c_eff;
    logic [ERR_W-1:0]       st_err;
    logic                   group_err;
    logic                   results_ready;

    pea_fifo_pop #(.WIDTH(status_size)) u_status_pop (
        .clk     (clk),
        .rst     (rst),
        .pop     (st_pop),
        .avail   (status_population != '0),
        .rd_data (status_data),
        .rd_en   (status_rd_en),
        .data    (status_hold)
    );

    pea_fifo_pop #(.WIDTH(result_size)) u_result_pop (
        .clk     (clk),
        .rst     (rst),
        .pop     (res_pop),
        .avail   (result_population != '0),
        .rd_data (result_data),
        .rd_en   (result_rd_en),
        .data    (result_hold)
    );

    // An errored status carries no results, whatever its count field says.
    assign st_err        = status_hold[ERR_LSB +: ERR_W];
    assign group_err     = (st_err != ERR_NONE);
    assign c_eff         = group_err ? '0 : status_hold[COUNT_LSB +: COUNT_W];
    assign results_ready = (result_population >= POP_W'(c_eff));

`ifdef PEA_READER_TIMEOUT_EN
    localparam int TO_W = log2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_expired;

    assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_WAIT_RES && next_state == S_WAIT_RES) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
        end else begin
            state <= next_state;
            if (load_remaining) begin
                remaining <= c_eff;
            end else if (state == S_SEND_RES && out_ready) begin
                remaining <= remaining - COUNT_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        next_state     = state;
        st_pop         = 1'b0;
        res_pop        = 1'b0;
        load_remaining = 1'b0;
        out_valid      = 1'b0;
        out_is_status  = 1'b0;
        out_last       = 1'b0;
        out_err        = 1'b0;
        out_data       = '0;

        case (state)
            S_IDLE: begin
                if (status_population != '0) next_state = S_POP_ST;
            end
            S_POP_ST: begin
                st_pop     = 1'b1;
                next_state = S_LAT_ST;
            end
            S_LAT_ST: begin
                next_state = S_SEND_ST;
            end
            S_SEND_ST: begin
                out_valid     = 1'b1;
                out_is_status = 1'b1;
                out_last      = (c_eff == '0);
                out_err       = group_err;
                out_data      = result_size'(status_hold);
                if (out_ready) next_state = (c_eff == '0) ? S_IDLE : S_WAIT_RES;
            end
            S_WAIT_RES: begin
                out_err = group_err;
                // All-or-nothing: pop only once the whole group is present.
                if (results_ready) begin
                    load_remaining = 1'b1;
                    next_state     = S_POP_RES;
                end
`ifdef PEA_READER_TIMEOUT_EN
                else if (to_expired) begin
                    next_state = S_SEND_TO;
                end
`endif
            end
            S_POP_RES: begin
                out_err    = group_err;
                res_pop    = 1'b1;
                next_state = S_LAT_RES;
            end
            S_LAT_RES: begin
                out_err    = group_err;
                next_state = S_SEND_RES;
            end
            S_SEND_RES: begin
                out_valid = 1'b1;
                out_last  = (remaining == COUNT_W'(1));
                out_err   = group_err;
                out_data  = result_hold;
                if (out_ready) next_state = (remaining == COUNT_W'(1)) ? S_IDLE : S_POP_RES;
            end
`ifdef PEA_READER_TIMEOUT_EN
            S_SEND_TO: begin
                out_valid     = 1'b1;
                out_is_status = 1'b1;
                out_last      = 1'b1;
                out_err       = 1'b1;
                out_data      = result_size'({status_hold[OPCODE_LSB +: OPCODE_W],
                                              {COUNT_W{1'b0}}, ERR_TIMEOUT});
                if (out_ready) next_state = S_IDLE;
            end
`endif
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pea_result_reader.sv
// Directed scoreboard bench for pea_result_reader: FIFO models on both inputs,
// expected beats queued at stimulus time and compared on each handshake.
module tb_pea_result_reader;
    import pea_pkg::*;

    localparam int BUF   = 1024;
    localparam int RES_W = 32;
    localparam int ST_W  = 16;
    localparam int POP_W = log2(BUF);
    localparam int TO    = 16;

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic             is_status;
        logic             last;
        logic             err;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [POP_W-1:0] status_population = '0;
    logic             status_rd_en;
    logic [ST_W-1:0]  status_data = '0;
    logic [POP_W-1:0] result_population = '0;
    logic             result_rd_en;
    logic [RES_W-1:0] result_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [RES_W-1:0] out_data;
    logic             out_is_status;
    logic             out_last;
    logic             out_err;

    beat_t            exp_q[$];
    logic [ST_W-1:0]  st_fifo[$];
    logic [RES_W-1:0] res_fifo[$];
    int               tests    = 0;
    int               fails    = 0;
    int               st_pops  = 0;
    int               res_pops = 0;
    logic             stall_prev = 1'b0;
    beat_t            stall_beat;

    always #5 clk = ~clk;

    pea_result_reader #(
        .buffer_size    (BUF),
        .result_size    (RES_W),
        .status_size    (ST_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .status_population (status_population),
        .status_rd_en      (status_rd_en),
        .status_data       (status_data),
        .result_population (result_population),
        .result_rd_en      (result_rd_en),
        .result_data       (result_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_is_status     (out_is_status),
        .out_last          (out_last),
        .out_err           (out_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor beats on the falling edge, model the FIFOs just after the rising edge.
    task automatic step();
        logic  s, r;
        beat_t e;
        @(negedge clk);
        if (!rst) begin
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'(1'b1));
                check("stall_data", 64'(out_data), 64'(stall_beat.data));
                check("stall_flags", 64'({out_is_status, out_last, out_err}),
                      64'({stall_beat.is_status, stall_beat.last, stall_beat.err}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(out_data), 64'(e.data));
                    check("beat_flags", 64'({out_is_status, out_last, out_err}),
                          64'({e.is_status, e.last, e.err}));
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_beat = '{data: out_data, is_status: out_is_status, last: out_last, err: out_err};
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        s = status_rd_en;
        r = result_rd_en;
        if (!rst) begin
            check("st_rd_on_empty", 64'(s && (status_population == '0)), 64'(0));
            check("res_rd_on_empty", 64'(r && (result_population == '0)), 64'(0));
            check("both_rd_en", 64'(s && r), 64'(0));
        end
        #1;
        if (s && st_fifo.size() != 0) begin
            status_data = st_fifo.pop_front();
            st_pops++;
        end
        if (r && res_fifo.size() != 0) begin
            result_data = res_fifo.pop_front();
            res_pops++;
        end
        status_population = POP_W'(st_fifo.size());
        result_population = POP_W'(res_fifo.size());
    endtask

    // Pushing a status token also queues the beat it must produce.
    task automatic push_status(input logic [ST_W-1:0] v);
        logic [2:0] e_code;
        logic [4:0] cnt;
        e_code = v[2:0];
        cnt    = v[7:3];
        st_fifo.push_back(v);
        status_population = POP_W'(st_fifo.size());
        exp_q.push_back('{data: {16'h0, v}, is_status: 1'b1,
                          last: (e_code != 3'b000) || (cnt == 5'd0), err: (e_code != 3'b000)});
    endtask

    task automatic push_result(input logic [RES_W-1:0] v, input logic expect_it, input logic last);
        res_fifo.push_back(v);
        result_population = POP_W'(res_fifo.size());
        if (expect_it) exp_q.push_back('{data: v, is_status: 1'b0, last: last, err: 1'b0});
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_exp(input string tag, input int size, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != size && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'(size));
    endtask

    task automatic wait_result_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!(out_valid && !out_is_status) && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(out_valid && !out_is_status), 64'(1));
    endtask

    initial begin
        int r0;

        // Reset state
        repeat (3) step();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_flags", 64'({out_is_status, out_last, out_err}), 64'(0));
        check("rst_rd_en", 64'({status_rd_en, result_rd_en}), 64'(0));
        rst = 1'b0;
        step();
        check("idle_valid", 64'(out_valid), 64'(0));

        // Group 0x2A10: C=2, results 5 and -7; latency 3 cycles to first beat
        out_ready = 1'b1;
        r0 = res_pops;
        push_status(16'h2A10);
        push_result(32'd5, 1'b1, 1'b0);
        push_result(32'hFFFF_FFF9, 1'b1, 1'b1);
        step();
        step();
        check("latency_before", 64'(out_valid), 64'(0));
        step();
        check("latency_at_3", 64'(out_valid), 64'(1));
        drain("drain_basic", 60);
        check("basic_res_pops", 64'(res_pops - r0), 64'(2));
        check("basic_st_pops", 64'(st_pops), 64'(1));

        // C=3 with only two results present: no partial reads
        r0 = res_pops;
        push_status(16'h1118);
        push_result(32'd10, 1'b1, 1'b0);
        push_result(32'd20, 1'b1, 1'b0);
        repeat (50) step();
        check("partial_no_pop", 64'(res_pops - r0), 64'(0));
        check("partial_pending", 64'(exp_q.size()), 64'(2));
        push_result(32'd30, 1'b1, 1'b1);
        drain("drain_partial", 60);
        check("partial_res_pops", 64'(res_pops - r0), 64'(3));

        // Error status E=010, C=4: single errored status beat, results untouched
        r0 = res_pops;
        push_status(16'h3322);
        for (int i = 0; i < 4; i++) push_result(32'(100 + i), 1'b0, 1'b0);
        drain("drain_err", 30);
        repeat (10) step();
        check("err_no_pop", 64'(res_pops - r0), 64'(0));
        check("err_fifo_left", 64'(res_fifo.size()), 64'(4));
        res_fifo.delete();
        result_population = '0;

        // Back-pressure for 20 cycles on a result beat
        r0 = res_pops;
        push_status(16'h4408);
        push_result(32'h1234_5678, 1'b1, 1'b1);
        wait_exp("stall_status_sent", 1, 30);
        out_ready = 1'b0;
        wait_result_valid("stall_res_valid", 30);
        repeat (20) step();
        check("stall_data_held", 64'(out_data), 64'(32'h1234_5678));
        check("stall_one_pop", 64'(res_pops - r0), 64'(1));
        out_ready = 1'b1;
        drain("drain_stall", 10);
        check("stall_total_pops", 64'(res_pops - r0), 64'(1));

        // Reset in S_SEND_RES with two results still to go
        push_status(16'h5510);
        push_result(32'd1, 1'b1, 1'b0);
        push_result(32'd2, 1'b1, 1'b1);
        wait_exp("rst_status_sent", 2, 30);
        out_ready = 1'b0;
        wait_result_valid("rst_res_valid", 30);
        check("rst_remaining", 64'(dut.remaining), 64'(2));
        rst = 1'b1;
        step();
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_rd_en", 64'({status_rd_en, result_rd_en}), 64'(0));
        check("midrst_state", 64'(dut.state), 64'(S_IDLE));
        rst = 1'b0;
        exp_q.delete();
        res_fifo.delete();
        result_population = '0;
        out_ready = 1'b1;
        repeat (5) step();
        check("post_rst_idle", 64'(out_valid), 64'(0));

`ifdef PEA_READER_TIMEOUT_EN
        // Watchdog: C=1, no results ever arrive
        r0 = res_pops;
        push_status(16'h6608);
        exp_q.push_back('{data: {16'h0, 8'h66, 5'd0, 3'b111}, is_status: 1'b1, last: 1'b1, err: 1'b1});
        wait_exp("to_status_sent", 1, 30);
        begin
            int n;
            n = 0;
            while (!out_valid && n < TO + 1) begin
                step();
                n++;
            end
            check("to_within_limit", 64'(out_valid), 64'(1));
        end
        drain("drain_timeout", 5);
        check("to_no_pop", 64'(res_pops - r0), 64'(0));
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pea_result_reader.md
Name: pea_result_reader

Overview:
- Consumer-side drain for the PEA output path. Pops status tokens and their associated result tokens from the status and result FIFOs that the PEA core writes.
- Serializes the tokens onto one valid/ready stream toward the host interface.
- Mirrors the core's all-or-nothing firing rule: a token group is read only when the whole group is present in the FIFOs.

Parameters:
- buffer_size, 1024: words per FIFO. Population port width is log2(buffer_size), using the team's log2 function.
- result_size, 32: result token width (signed 2's complement).
- status_size, 16: status token width.
- TIMEOUT_CYCLES, 4096: watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- status_population  in  log2(buffer_size)  tokens currently in status FIFO
- status_rd_en  out  1  pop strobe for status FIFO
- status_data  in  status_size  status FIFO read data, valid 1 cycle after status_rd_en
- result_population  in  log2(buffer_size)  tokens currently in result FIFO
- result_rd_en  out  1  pop strobe for result FIFO
- result_data  in  result_size  result FIFO read data, valid 1 cycle after result_rd_en
- out_valid  out  1  stream beat valid
- out_ready  in  1  host accepts beat
- out_data  out  result_size  beat payload; status beats are zero-extended
- out_is_status  out  1  beat is a status token
- out_last  out  1  final beat of the current group
- out_err  out  1  status error code nonzero; held for the whole group

Behaviour:
- Status token fields:
  - [15:8] opcode echo
  - [7:3] result count C (0..31)
  - [2:0] error code E
  - If E != 0, C is treated as 0.
- Reset: all outputs are 0 and the FSM enters S_IDLE. A reset mid-group abandons the group; tokens already popped are lost, and the bench must not expect them.
- FSM states and transitions:
  - S_IDLE: if status_population >= 1, go to S_POP_ST.
  - S_POP_ST: status_rd_en = 1 for exactly 1 cycle; go to S_LAT_ST.
  - S_LAT_ST: latch status_data; compute C_eff; go to S_SEND_ST.
  - S_SEND_ST: out_valid = 1, out_is_status = 1, out_last = (C_eff == 0).
    - On out_valid && out_ready: if C_eff == 0, go to S_IDLE; else go to S_WAIT_RES.
  - S_WAIT_RES: if result_population >= C_eff, load remaining = C_eff and go to S_POP_RES. Otherwise stay; no partial reads.
  - S_POP_RES: result_rd_en = 1 for 1 cycle; go to S_LAT_RES.
  - S_LAT_RES: latch result_data; go to S_SEND_RES.
  - S_SEND_RES: out_valid = 1, out_is_status = 0, out_last = (remaining == 1).
    - On handshake: decrement remaining; if it reaches 0, go to S_IDLE, else go to S_POP_RES.
- Handshake rules: out_data, out_is_status, out_last and out_err are stable while out_valid && !out_ready. out_valid never drops without a handshake.
- Read-enable rules: rd_en is never asserted while the target population is 0. The two rd_en outputs are never high in the same cycle.
- Throughput: 3 cycles per beat minimum (pop, latch, send). Best-case latency from status_population rising to 1 until out_valid is 3 cycles.
- Population counts are treated as unsigned. Comparison against C_eff zero-extends C_eff to the population width.
- Simultaneous status and result availability: status is always handled first; results are consumed only against a latched count.

Optional Feature:
- Macro: PEA_READER_TIMEOUT_EN.
- With the macro: a counter runs in S_WAIT_RES. When it reaches TIMEOUT_CYCLES, the block emits one synthetic status beat and returns to S_IDLE without popping any results.
  - Synthetic beat: out_is_status = 1, out_last = 1, out_err = 1, payload = {opcode echo, 5'd0, 3'b111}.
  - The counter clears on state exit and on reset.
- Without the macro: S_WAIT_RES waits indefinitely, and no counter logic is present.

Decomposition:
- Shared package (pea_pkg), used alongside the PEA core:
  - status field offsets and widths
  - error-code constants, including ERR_TIMEOUT = 3'b111
  - FSM state encoding localparams
  - the log2 function
- Sub-module pea_fifo_pop: a single FIFO pop/latch helper (strobe, 1-cycle capture, hold register), instantiated twice, once for status and once for results.

Test Plan:
- Status 0x2A10 (C = 2, E = 0), result FIFO holds 5 and -7 → three beats: 0x00002A10 (status), 5, 0xFFFFFFF9; out_last only on the third beat.
- Status C = 3, result_population = 2 for 50 cycles → no result_rd_en during that window. Raise the population to 3 → the three results stream out.
- Status E = 3'b010, C = 4 → one status beat with out_err = 1 and out_last = 1; zero result pops.
- out_ready held low for 20 cycles during a result beat → out_data is stable and exactly one pop occurs.
- Reset asserted in S_SEND_RES with remaining = 2 → next cycle out_valid = 0, both rd_en = 0, state S_IDLE.
- PEA_READER_TIMEOUT_EN with TIMEOUT_CYCLES = 16, C = 1, result_population = 0 → a synthetic error beat with code 3'b111 appears within 16 cycles; no result pop.
